led_group_ctrl: RTL and testbench
=================================

LED_GROUP_CTRL -- requirements
Module: led_group_ctrl

Interface
REQ-001 The block SHALL have parameter N_GROUPS, default 4: number of button/LED groups.
REQ-002 The block SHALL have parameter GROUP_W, default 4: switches/LEDs per group.
REQ-003 The block SHALL have parameter DEBOUNCE_CYCLES, default 1000000: stable cycles required to accept a button level (10 ms at 100 MHz); legal range is 2 or more.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state is on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port sw, input, N_GROUPS*GROUP_W bits: asynchronous switches; group g is sw[g*GROUP_W +: GROUP_W].
REQ-007 The block SHALL have port btn, input, N_GROUPS bits: asynchronous push-buttons, active-low (0 = pressed); btn[g] controls group g.
REQ-008 The block SHALL have port led, output, N_GROUPS*GROUP_W bits: registered LED drive; the group slicing is the same as sw.
REQ-009 The block SHALL have port group_active, output, N_GROUPS bits: registered live-mode flag per group.

Function
REQ-010 sw and btn SHALL each pass through a 2-flop synchroniser before any use.
REQ-011 Each button SHALL have an independent debouncer: a stable level (reset value 1) and a counter.
- The counter SHALL increment while the synchronised input differs from the stable level.
- The counter SHALL clear to 0 whenever the synchronised input equals the stable level.
REQ-012 When the counter reaches DEBOUNCE_CYCLES-1 with the input still differing, the stable level SHALL flip on that edge and the counter SHALL clear.
- Glitches shorter than DEBOUNCE_CYCLES cycles SHALL be ignored.
REQ-013 press_evt[g] SHALL be a one-cycle internal pulse on each 1->0 transition of stable level g.
- Release (0->1) SHALL produce no event.
REQ-014 The first press_evt[g] SHALL assert on the (2+DEBOUNCE_CYCLES)-th rising edge after btn[g] falls and stays low.
REQ-015 On an edge with press_evt[g]=1 and no clear (REQ-018), active[g] SHALL toggle.
- On the same edge, led group g SHALL load synchronised sw group g.
REQ-016 While active[g]=1, led group g SHALL load synchronised sw group g every cycle: sw-to-led latency is 3 cycles.
REQ-017 While active[g]=0, led group g SHALL hold its value, i.e. frozen at the last sampled switches.
REQ-018 Clear: on an edge where every stable level is 0 and at least one press_evt is 1, all active bits and all led bits SHALL go to 0.
- Clear SHALL take priority over REQ-015 and REQ-016.
REQ-019 Simultaneous press events on different groups SHALL each toggle their own group independently on the same edge, unless REQ-018 applies.
REQ-020 Holding a button SHALL produce exactly one toggle; a new toggle SHALL require a debounced release followed by a debounced press.
REQ-021 group_active SHALL equal active[] registered state; led and group_active SHALL have no combinational path from inputs.

Reset
REQ-022 While rst=1 at a clock edge, the block SHALL force:
- led = 0 and group_active = 0;
- all stable levels = 1 (released) and all debounce counters = 0;
- all synchroniser flops = 1 for btn and 0 for sw.
REQ-023 Reset asserted mid-debounce or mid-press SHALL discard the pending event.
- A button still held at reset release SHALL generate one press event after the full REQ-014 latency.

Structure
REQ-024 A shared package SHALL hold the default parameter values and the sync depth constant SYNC_STAGES=2.
REQ-025 The debouncer SHALL be a sub-module btn_debounce (synchroniser, counter, stable level, press pulse), instantiated N_GROUPS times by generate.
- Group/LED logic SHALL stay in led_group_ctrl.
REQ-026 The counter width SHALL be $clog2(DEBOUNCE_CYCLES).

Verification (bench uses DEBOUNCE_CYCLES=4, N_GROUPS=4, GROUP_W=4)
REQ-027 Reset: rst high 3 cycles, then low, sw=16'hFFFF, btn=4'hF -> led=16'h0000 and group_active=4'b0000 held for 20 cycles.
REQ-028 Activate: btn=4'b1110 held 10 cycles, sw=16'h1234 -> group_active=4'b0001 exactly 6 edges after the press and led[3:0]=4'h4.
- Then sw=16'h123A -> led[3:0]=4'hA 3 cycles later; led[15:4] stays 0.
REQ-029 Glitch and freeze: a 3-cycle low pulse on btn[0] -> no toggle.
- A full press/release of btn[0] -> group_active=4'b0000.
- Then sw changes to 16'h0005 -> led[3:0] stays 4'hA.
REQ-030 Simultaneous press: btn=4'b0101 held 10 cycles -> group_active=4'b1010 on one edge.
- Holding for 50 cycles produces no further toggles.
REQ-031 Clear: with groups 1 and 3 active, btn=4'b0000 with all four buttons falling together -> led=16'h0000 and group_active=4'b0000.
REQ-032 Reset mid-press: btn[2] low for 3 cycles, rst pulse, btn[2] kept low -> exactly one toggle, 6 edges after rst deasserts.

Source files
------------

// File: rtl/led_group_ctrl_pkg.sv
// Shared constants for the LED group controller.
//   DEF_*        : default parameter values for led_group_ctrl
//   SYNC_STAGES  : depth of every input synchroniser (btn and sw)
package led_group_ctrl_pkg;
  localparam int DEF_N_GROUPS        = 4;
  localparam int DEF_GROUP_W         = 4;
  localparam int DEF_DEBOUNCE_CYCLES = 1000000;
  localparam int SYNC_STAGES         = 2;
endpackage

// File: rtl/led_group_ctrl_btn_debounce.sv
// btn_debounce: synchroniser + debouncer for one active-low push-button.
//   clk, rst       : clock, synchronous active-high reset
//   btn_i          : raw asynchronous button (0 = pressed)
//   stable_o       : current debounced level (1 = released)
//   stable_nxt_o   : level the debouncer holds after this edge
//   press_evt_o    : high for the one cycle whose edge takes stable 1->0
module btn_debounce
  import led_group_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic stable_o,
  output logic stable_nxt_o,
  output logic press_evt_o
);
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   btn_s;

  assign btn_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d      = {sync_q[SYNC_STAGES-2:0], btn_i};
    cnt_d       = '0;
    stable_d    = stable_q;
    press_evt_o = 1'b0;
    if (btn_s != stable_q) begin
      // Flip on the DEBOUNCE_CYCLES-th consecutive differing cycle.
      if (cnt_q == CNT_MAX) begin
        stable_d    = ~stable_q;
        press_evt_o = stable_q;   // only the 1->0 flip is a press
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q   <= '1;
      cnt_q    <= '0;
      stable_q <= 1'b1;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
    end
  end

  assign stable_o     = stable_q;
  assign stable_nxt_o = stable_d;
endmodule

// File: rtl/led_group_ctrl.sv
// led_group_ctrl: N_GROUPS button-controlled LED groups.
//   clk, rst      : clock, synchronous active-high reset
//   sw            : async switches, group g = sw[g*GROUP_W +: GROUP_W]
//   btn           : async active-low buttons, btn[g] toggles group g
//   led           : registered LED drive, sliced like sw
//   group_active  : registered live-mode flag per group
// A debounced press toggles live mode; live groups track the switches,
// idle groups hold their last sample. Pressing the last released button
// (all buttons down) clears every group.
module led_group_ctrl
  import led_group_ctrl_pkg::*;
#(
  parameter int N_GROUPS        = DEF_N_GROUPS,
  parameter int GROUP_W         = DEF_GROUP_W,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [N_GROUPS*GROUP_W-1:0] sw,
  input  logic [N_GROUPS-1:0]         btn,
  output logic [N_GROUPS*GROUP_W-1:0] led,
  output logic [N_GROUPS-1:0]         group_active
);
  localparam int SW_W = N_GROUPS * GROUP_W;

  logic [SYNC_STAGES-1:0][SW_W-1:0] sw_sync_q, sw_sync_d;
  logic [SW_W-1:0]                  sw_s;
  logic [SW_W-1:0]                  led_q, led_d;
  logic [N_GROUPS-1:0]              active_q, active_d;
  logic [N_GROUPS-1:0]              stable, stable_nxt, press_evt;
  logic                             clear;

  for (genvar g = 0; g < N_GROUPS; g++) begin : g_deb
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb (
      .clk          (clk),
      .rst          (rst),
      .btn_i        (btn[g]),
      .stable_o     (stable[g]),
      .stable_nxt_o (stable_nxt[g]),
      .press_evt_o  (press_evt[g])
    );
  end

  assign sw_s = sw_sync_q[SYNC_STAGES-1];

  // Judged on the post-edge levels so that all buttons falling together
  // (all presses on one edge) still counts as "every button down".
  assign clear = ~|stable_nxt & |press_evt;

  always_comb begin
    sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], sw};
    active_d  = active_q;
    led_d     = led_q;
    if (clear) begin
      active_d = '0;
      led_d    = '0;
    end else begin
      for (int g = 0; g < N_GROUPS; g++) begin
        if (press_evt[g]) active_d[g] = ~active_q[g];
        // Load on the toggle edge too, so a group leaving live mode
        // freezes at the switches it saw on that edge.
        if (press_evt[g] || active_q[g])
          led_d[g*GROUP_W +: GROUP_W] = sw_s[g*GROUP_W +: GROUP_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sw_sync_q <= '0;
      active_q  <= '0;
      led_q     <= '0;
    end else begin
      sw_sync_q <= sw_sync_d;
      active_q  <= active_d;
      led_q     <= led_d;
    end
  end

  assign led          = led_q;
  assign group_active = active_q;
endmodule

// File: tb/tb_led_group_ctrl.sv
module tb_led_group_ctrl;
  localparam int NG = 4;
  localparam int GW = 4;
  localparam int DB = 4;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [NG*GW-1:0]   sw  = '0;
  logic [NG-1:0]      btn = '1;
  logic [NG*GW-1:0]   led;
  logic [NG-1:0]      group_active;

  int vectors = 0;
  int errors  = 0;

  led_group_ctrl #(.N_GROUPS(NG), .GROUP_W(GW), .DEBOUNCE_CYCLES(DB)) dut (
    .clk(clk), .rst(rst), .sw(sw), .btn(btn),
    .led(led), .group_active(group_active)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: inputs reach the logic two edges late; a button
  // level is accepted once the delayed input has disagreed with it for DB
  // consecutive edges; presses toggle/clear per the group rules.
  logic [NG-1:0]    m_stable, m_active, m_press, m_old;
  logic [NG*GW-1:0] m_led;
  int               m_run [NG];
  logic [NG-1:0]    btn_h [$];
  logic [NG*GW-1:0] sw_h  [$];
  bit               m_valid = 0;

  initial forever begin
    @(posedge clk);
    if (rst) begin
      m_stable = '1; m_active = '0; m_led = '0;
      for (int g = 0; g < NG; g++) m_run[g] = 0;
      btn_h = '{'1, '1};
      sw_h  = '{'0, '0};
      m_valid = 1;
    end else begin
      m_press = '0;
      for (int g = 0; g < NG; g++) begin
        if (btn_h[0][g] != m_stable[g]) begin
          m_run[g]++;
          if (m_run[g] == DB) begin
            m_stable[g] = ~m_stable[g];
            m_run[g] = 0;
            m_press[g] = ~m_stable[g];
          end
        end else m_run[g] = 0;
      end
      if (m_stable == '0 && m_press != '0) begin
        m_active = '0; m_led = '0;
      end else begin
        m_old = m_active;
        m_active = m_active ^ m_press;
        for (int g = 0; g < NG; g++)
          if (m_press[g] || m_old[g]) m_led[g*GW +: GW] = sw_h[0][g*GW +: GW];
      end
      void'(btn_h.pop_front()); btn_h.push_back(btn);
      void'(sw_h.pop_front());  sw_h.push_back(sw);
    end
  end

  // Compare process: outputs against model every cycle once reset was seen.
  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      chk("model_led", 32'(led), 32'(m_led));
      chk("model_active", 32'(group_active), 32'(m_active));
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Apply btn and count edges until group_active[g] first rises (0 = never).
  task automatic press_count(input logic [NG-1:0] b, input int g, input int n, output int first);
    logic prev;
    prev = group_active[g];
    first = 0;
    btn = b;
    for (int i = 1; i <= n; i++) begin
      @(negedge clk);
      if (first == 0 && group_active[g] && !prev) first = i;
    end
  endtask

  int first, changes;
  logic [NG-1:0] last_ga;

  initial begin
    // Reset and idle
    rst = 1'b1; step(3);
    rst = 1'b0; sw = 16'hFFFF; btn = 4'hF;
    step(20);
    chk("reset_led", 32'(led), 32'h0);
    chk("reset_active", 32'(group_active), 32'h0);

    // Activate group 0
    sw = 16'h1234;
    press_count(4'b1110, 0, 10, first);
    chk("press_latency", first, 6);
    chk("act_active", 32'(group_active), 32'h1);
    chk("act_led", 32'(led), 32'h0004);
    btn = 4'hF; sw = 16'h123A;
    step(3);
    chk("live_led", 32'(led), 32'h000A);
    step(10);

    // Glitch ignored, full press freezes
    btn = 4'b1110; step(3);
    btn = 4'hF;    step(10);
    chk("glitch_active", 32'(group_active), 32'h1);
    btn = 4'b1110; step(10);
    btn = 4'hF;    step(10);
    chk("off_active", 32'(group_active), 32'h0);
    sw = 16'h0005; step(10);
    chk("freeze_led", 32'(led), 32'h000A);

    // Simultaneous press on groups 1 and 3, held long
    sw = 16'hBCD5;
    btn = 4'b0101;
    changes = 0; last_ga = group_active;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (group_active != last_ga) changes++;
      last_ga = group_active;
    end
    chk("simul_changes", changes, 1);
    chk("simul_active", 32'(group_active), 32'hA);
    chk("simul_led", 32'(led), 32'hB0DA);
    btn = 4'hF; step(10);

    // All four fall together -> clear
    btn = 4'b0000; step(10);
    chk("clear_led", 32'(led), 32'h0);
    chk("clear_active", 32'(group_active), 32'h0);
    btn = 4'hF; step(10);

    // Reset mid-press, button still held
    btn = 4'b1011; step(3);
    rst = 1'b1; step(2);
    rst = 1'b0;
    press_count(4'b1011, 2, 20, first);
    chk("rst_press_latency", first, 6);
    chk("rst_press_active", 32'(group_active), 32'h4);
    btn = 4'hF; step(10);

    // Randomised soak: bouncy buttons, wandering switches, rare resets
    for (int i = 0; i < 3000; i++) begin
      for (int g = 0; g < NG; g++)
        if ($urandom_range(5) == 0) btn[g] = ~btn[g];
      if ($urandom_range(3) == 0) sw = 16'($urandom);
      rst = ($urandom_range(499) == 0);
      @(negedge clk);
    end
    rst = 1'b0; btn = 4'hF; step(10);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
